// File: rtl/cmul_pipe_if.sv
// Handshake and data bundle for cmul_pipe: input transaction side plus output result side.
// slave is the multiplier's view; master is the producer/consumer view.
interface cmul_pipe_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DIN_W  = 256,
  parameter int unsigned NLIMB  = 5,
  parameter int unsigned LIMB_W = 52,
  parameter int unsigned SH_W   = 2,
  parameter int unsigned TAG_W  = 4
);
  logic                              in_valid;
  logic                              in_ready;
  logic [TAG_W-1:0]                  in_tag;
  logic                              in_en_a;
  logic [SH_W-1:0]                   in_sh_a;
  logic                              in_en_b;
  logic [SH_W-1:0]                   in_sh_b;
  logic [LANES*DIN_W-1:0]            in_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [TAG_W-1:0]                  out_tag;
  logic                              out_err;
  logic [LANES*NLIMB*(LIMB_W+1)-1:0] out_data;

  modport master (
    output in_valid, in_tag, in_en_a, in_sh_a, in_en_b, in_sh_b, in_data, out_ready,
    input  in_ready, out_valid, out_tag, out_err, out_data
  );

  modport slave (
    input  in_valid, in_tag, in_en_a, in_sh_a, in_en_b, in_sh_b, in_data, out_ready,
    output in_ready, out_valid, out_tag, out_err, out_data
  );
endinterface

// File: rtl/cmul_pipe.sv
// Multi-lane multiply by c = en_a*2^sh_a + en_b*2^sh_b, producing per-limb carry-save sums
// through an elastic valid/ready pipeline of 1..3 stages.
module cmul_pipe #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned DIN_W     = 256,
  parameter int unsigned NLIMB     = 5,
  parameter int unsigned LIMB_W    = 52,
  parameter int unsigned MAX_SHIFT = 3,
  parameter int unsigned SH_W      = 2,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned TAG_W     = 4
) (
  input logic        clk,
  input logic        rst,
  cmul_pipe_if.slave bus
);
  localparam int unsigned PW = NLIMB * LIMB_W;        // polynomial width per lane
  localparam int unsigned OW = LIMB_W + 1;            // output limb width
  localparam int unsigned TW = LANES * PW;            // all lanes of one shifted term
  localparam int unsigned SW = LANES * NLIMB * OW;    // all lanes of limb sums

  if (NLIMB * LIMB_W < DIN_W + MAX_SHIFT) begin : g_bad_width
    $error("cmul_pipe: NLIMB*LIMB_W must be >= DIN_W+MAX_SHIFT");
  end
  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("cmul_pipe: STAGES must be 1..3");
  end

  logic          a_legal, b_legal, a_use, b_use, err_in;
  logic [TW-1:0] a_in, b_in;

  // An enabled term with an out-of-range shift is dropped and flagged.
  always_comb begin
    a_legal = 32'(bus.in_sh_a) <= MAX_SHIFT;
    b_legal = 32'(bus.in_sh_b) <= MAX_SHIFT;
    a_use   = bus.in_en_a & a_legal;
    b_use   = bus.in_en_b & b_legal;
    err_in  = (bus.in_en_a & ~a_legal) | (bus.in_en_b & ~b_legal);
    a_in    = '0;
    b_in    = '0;
    for (int k = 0; k < LANES; k++) begin
      if (a_use) a_in[k*PW +: PW] = PW'(bus.in_data[k*DIN_W +: DIN_W]) << bus.in_sh_a;
      if (b_use) b_in[k*PW +: PW] = PW'(bus.in_data[k*DIN_W +: DIN_W]) << bus.in_sh_b;
    end
  end

  function automatic logic [SW-1:0] limb_sum(input logic [TW-1:0] a, input logic [TW-1:0] b);
    logic [SW-1:0] s;
    s = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int j = 0; j < NLIMB; j++) begin
        s[(k*NLIMB+j)*OW +: OW] = OW'(a[k*PW + j*LIMB_W +: LIMB_W])
                                + OW'(b[k*PW + j*LIMB_W +: LIMB_W]);
      end
    end
    return s;
  endfunction

  if (STAGES == 1) begin : g_one
    logic             valid_q, valid_d, err_q, err_d, load;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [SW-1:0]    data_q, data_d;

    always_comb begin
      load    = ~valid_q | bus.out_ready;
      valid_d = valid_q;
      err_d   = err_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (load) begin
        valid_d = bus.in_valid;
        if (bus.in_valid) begin
          err_d  = err_in;
          tag_d  = bus.in_tag;
          data_d = limb_sum(a_in, b_in);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        tag_q   <= '0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        err_q   <= err_d;
        tag_q   <= tag_d;
        data_q  <= data_d;
      end
    end

    assign bus.in_ready  = load;
    assign bus.out_valid = valid_q;
    assign bus.out_err   = err_q;
    assign bus.out_tag   = tag_q;
    assign bus.out_data  = data_q;
  end else begin : g_multi
    logic             s1_valid_q, s1_valid_d, s1_err_q, s1_err_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [TW-1:0]    s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic             s2_valid_q, s2_valid_d, s2_err_q, s2_err_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic [SW-1:0]    s2_data_q, s2_data_d;
    logic             s1_load, s2_load, s2_down;

    // A stage loads when empty or when its content leaves this cycle.
    assign s2_load      = ~s2_valid_q | s2_down;
    assign s1_load      = ~s1_valid_q | s2_load;
    assign bus.in_ready = s1_load;

    always_comb begin
      s1_valid_d = s1_valid_q;
      s1_err_d   = s1_err_q;
      s1_tag_d   = s1_tag_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      if (s1_load) begin
        s1_valid_d = bus.in_valid;
        if (bus.in_valid) begin
          s1_err_d = err_in;
          s1_tag_d = bus.in_tag;
          s1_a_d   = a_in;
          s1_b_d   = b_in;
        end
      end
    end

    always_comb begin
      s2_valid_d = s2_valid_q;
      s2_err_d   = s2_err_q;
      s2_tag_d   = s2_tag_q;
      s2_data_d  = s2_data_q;
      if (s2_load) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_err_d  = s1_err_q;
          s2_tag_d  = s1_tag_q;
          s2_data_d = limb_sum(s1_a_q, s1_b_q);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_err_q   <= 1'b0;
        s1_tag_q   <= '0;
        s1_a_q     <= '0;
        s1_b_q     <= '0;
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_tag_q   <= '0;
        s2_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_err_q   <= s1_err_d;
        s1_tag_q   <= s1_tag_d;
        s1_a_q     <= s1_a_d;
        s1_b_q     <= s1_b_d;
        s2_valid_q <= s2_valid_d;
        s2_err_q   <= s2_err_d;
        s2_tag_q   <= s2_tag_d;
        s2_data_q  <= s2_data_d;
      end
    end

    if (STAGES == 3) begin : g_s3
      logic             s3_valid_q, s3_valid_d, s3_err_q, s3_err_d, s3_load;
      logic [TAG_W-1:0] s3_tag_q, s3_tag_d;
      logic [SW-1:0]    s3_data_q, s3_data_d;

      assign s3_load = ~s3_valid_q | bus.out_ready;
      assign s2_down = s3_load;

      always_comb begin
        s3_valid_d = s3_valid_q;
        s3_err_d   = s3_err_q;
        s3_tag_d   = s3_tag_q;
        s3_data_d  = s3_data_q;
        if (s3_load) begin
          s3_valid_d = s2_valid_q;
          if (s2_valid_q) begin
            s3_err_d  = s2_err_q;
            s3_tag_d  = s2_tag_q;
            s3_data_d = s2_data_q;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s3_valid_q <= 1'b0;
          s3_err_q   <= 1'b0;
          s3_tag_q   <= '0;
          s3_data_q  <= '0;
        end else begin
          s3_valid_q <= s3_valid_d;
          s3_err_q   <= s3_err_d;
          s3_tag_q   <= s3_tag_d;
          s3_data_q  <= s3_data_d;
        end
      end

      assign bus.out_valid = s3_valid_q;
      assign bus.out_err   = s3_err_q;
      assign bus.out_tag   = s3_tag_q;
      assign bus.out_data  = s3_data_q;
    end else begin : g_s2_out
      assign s2_down       = bus.out_ready;
      assign bus.out_valid = s2_valid_q;
      assign bus.out_err   = s2_err_q;
      assign bus.out_tag   = s2_tag_q;
      assign bus.out_data  = s2_data_q;
    end
  end
endmodule

// File: tb/tb_cmul_pipe.sv
// Scoreboard bench for cmul_pipe: directed vectors push expectations, a negedge monitor
// pops and compares results, and checks in_ready, stall stability and latency.
module tb_cmul_pipe;
  localparam int unsigned LANES     = 2;
  localparam int unsigned DIN_W     = 256;
  localparam int unsigned NLIMB     = 5;
  localparam int unsigned LIMB_W    = 52;
  localparam int unsigned MAX_SHIFT = 3;
  localparam int unsigned SH_W      = 3;
  localparam int unsigned STAGES    = 2;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned OW        = LIMB_W + 1;
  localparam int unsigned OUTW      = LANES * NLIMB * OW;
  localparam int unsigned CW        = OUTW + 8;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             err;
    logic [OUTW-1:0]  data;
  } exp_t;

  exp_t exp_q[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic pat_en = 1'b0;
  int   passed = 0;
  int   total = 0;
  int   occ = 0;
  int   pi = 0;
  bit   pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  logic             stall = 1'b0;
  logic             h_err;
  logic [TAG_W-1:0] h_tag;
  logic [OUTW-1:0]  h_data;

  cmul_pipe_if #(
    .LANES(LANES), .DIN_W(DIN_W), .NLIMB(NLIMB), .LIMB_W(LIMB_W), .SH_W(SH_W), .TAG_W(TAG_W)
  ) bus ();

  assign bus.out_ready = rdy;

  cmul_pipe #(
    .LANES(LANES), .DIN_W(DIN_W), .NLIMB(NLIMB), .LIMB_W(LIMB_W), .MAX_SHIFT(MAX_SHIFT),
    .SH_W(SH_W), .STAGES(STAGES), .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: got event, required none", name);
  endtask

  function automatic logic [OUTW-1:0] limb(input logic [OUTW-1:0] v, input int k, input int j,
                                           input logic [OW-1:0] x);
    logic [OUTW-1:0] r;
    r = v;
    r[(k*NLIMB+j)*OW +: OW] = x;
    return r;
  endfunction

  // Presents one transaction and returns just after its accepting edge, valid still high.
  task automatic send(input logic [TAG_W-1:0] tag, input logic ea, input logic [SH_W-1:0] sa,
                      input logic eb, input logic [SH_W-1:0] sb, input logic [DIN_W-1:0] d0,
                      input logic [DIN_W-1:0] d1, input bit push, input logic err,
                      input logic [OUTW-1:0] data);
    exp_t e;
    int   tries;
    tries = 0;
    bus.in_valid = 1'b1;
    bus.in_tag   = tag;
    bus.in_en_a  = ea;
    bus.in_sh_a  = sa;
    bus.in_en_b  = eb;
    bus.in_sh_b  = sb;
    bus.in_data  = {d1, d0};
    if (push) begin
      e.tag  = tag;
      e.err  = err;
      e.data = data;
      exp_q.push_back(e);
    end
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      tries++;
      if (tries > 100) begin
        fail("send_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic latency(input string name);
    int k;
    k = 1;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      k++;
      if (k > 20) break;
    end
    chk(name, CW'(k), CW'(STAGES));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain", CW'(exp_q.size()), CW'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (pat_en) begin
      rdy = pat[pi];
      pi  = (pi + 1) % 7;
    end else begin
      rdy = 1'b1;
    end
  end

  // Monitor: handshakes seen here take effect at the following rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      occ   = 0;
      stall = 1'b0;
    end else begin
      chk("in_ready", CW'(bus.in_ready), CW'(!(occ == STAGES && !bus.out_ready)));
      if (stall)
        chk("stall_hold", CW'({bus.out_valid, bus.out_err, bus.out_tag, bus.out_data}),
            CW'({1'b1, h_err, h_tag, h_data}));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          chk("out_tag", CW'(bus.out_tag), CW'(e.tag));
          chk("out_err", CW'(bus.out_err), CW'(e.err));
          chk("out_data", CW'(bus.out_data), CW'(e.data));
        end
      end
      occ = occ + int'(bus.in_valid && bus.in_ready) - int'(bus.out_valid && bus.out_ready);
      stall  = bus.out_valid && !bus.out_ready;
      h_err  = bus.out_err;
      h_tag  = bus.out_tag;
      h_data = bus.out_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OUTW-1:0]  e;
    logic [DIN_W-1:0] big;
    int               sa, sb, c;
    bit               eb;

    bus.in_valid = 1'b0;
    bus.in_tag   = '0;
    bus.in_en_a  = 1'b0;
    bus.in_sh_a  = '0;
    bus.in_en_b  = 1'b0;
    bus.in_sh_b  = '0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", CW'({bus.out_valid, bus.out_err, bus.out_tag, bus.out_data}), CW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", CW'(bus.in_ready), CW'(1));
    @(posedge clk);
    #1;

    // c=3 on a small operand, with latency measured from the accepting edge
    e = limb('0, 0, 0, OW'(15));
    send(4'd7, 1'b1, 3'd1, 1'b1, 3'd0, DIN_W'(5), DIN_W'(0), 1'b1, 1'b0, e);
    bus.in_valid = 1'b0;
    latency("latency_first");
    drain();

    // term a crosses into limb1 while term b stays in limb0
    big = '0;
    big[51] = 1'b1;
    e = limb(limb('0, 0, 0, OW'(1) << 51), 0, 1, OW'(1));
    send(4'd1, 1'b1, 3'd1, 1'b1, 3'd0, big, DIN_W'(0), 1'b1, 1'b0, e);
    // full-width limb sum on lane1
    e = limb('0, 1, 0, {{(OW-1){1'b1}}, 1'b0});
    send(4'd3, 1'b1, 3'd0, 1'b1, 3'd0, DIN_W'(0), DIN_W'({LIMB_W{1'b1}}), 1'b1, 1'b0, e);
    // constant 0 with out-of-range shifts on disabled terms
    send(4'd4, 1'b0, 3'd7, 1'b0, 3'd7, DIN_W'(123), DIN_W'(456), 1'b1, 1'b0, '0);
    // illegal sh_b=5 dropped; din<<3 reaches the top limb
    big = '0;
    big[255] = 1'b1;
    big[0] = 1'b1;
    e = limb(limb(limb('0, 0, 0, OW'(8)), 0, 4, OW'(1) << 50), 1, 0, OW'(72));
    send(4'd5, 1'b1, 3'd3, 1'b1, 3'd5, big, DIN_W'(9), 1'b1, 1'b1, e);
    // only term enabled is illegal
    send(4'd6, 1'b1, 3'd4, 1'b0, 3'd0, DIN_W'(11), DIN_W'(13), 1'b1, 1'b1, '0);
    // disabled illegal term a, legal term b
    e = limb(limb('0, 0, 0, OW'(12)), 1, 0, OW'(20));
    send(4'd8, 1'b0, 3'd6, 1'b1, 3'd2, DIN_W'(3), DIN_W'(5), 1'b1, 1'b0, e);
    bus.in_valid = 1'b0;
    drain();

    // back-to-back stream under a stalling consumer
    pat_en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      sa = t % 4;
      sb = (t + 1) % 4;
      eb = (t != 3);
      c  = (1 << sa) + (eb ? (1 << sb) : 0);
      e  = limb(limb('0, 0, 0, OW'((t + 1) * c)), 1, 0, OW'((3 * t + 2) * c));
      send(TAG_W'(t), 1'b1, SH_W'(sa), eb, SH_W'(sb), DIN_W'(t + 1), DIN_W'(3 * t + 2),
           1'b1, 1'b0, e);
    end
    bus.in_valid = 1'b0;
    drain();
    pat_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset with two transactions in flight; they must never appear
    send(4'd9, 1'b1, 3'd0, 1'b0, 3'd0, DIN_W'(1), DIN_W'(1), 1'b0, 1'b0, '0);
    send(4'd10, 1'b1, 3'd0, 1'b0, 3'd0, DIN_W'(2), DIN_W'(2), 1'b0, 1'b0, '0);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("reset_midflight", CW'({bus.out_valid, bus.out_err, bus.out_tag, bus.out_data}),
        CW'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_midreset", CW'({bus.in_ready, bus.out_valid}), CW'(2'b10));
    @(posedge clk);
    #1;
    e = limb(limb('0, 0, 0, OW'(21)), 1, 0, OW'(22));
    send(4'd2, 1'b1, 3'd0, 1'b0, 3'd0, DIN_W'(21), DIN_W'(22), 1'b1, 1'b0, e);
    bus.in_valid = 1'b0;
    latency("latency_after_reset");
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
